// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the EX/WB writeback arbiter.
package cv32e40p_pkg;

  // Arbitration policy across result sources.
  typedef enum logic {
    WB_PRIO_FIXED = 1'b0,
    WB_PRIO_RR    = 1'b1
  } wb_prio_e;

  // Conventional source slot assignment.
  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_X   = 1;
  localparam int unsigned WB_SRC_LSU = 2;

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// Small per-source writeback FIFO; arbitrary depth, no bypass.
module cv32e40p_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 38,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else                        return p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// Multi-source register-file writeback arbiter with per-source buffering.
module cv32e40p_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 32,
  parameter wb_prio_e    PRIO_MODE = WB_PRIO_FIXED
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] src_waddr_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] src_wdata_i,
  output logic                           rf_we_o,
  output logic [ADDR_W-1:0]              rf_waddr_o,
  output logic [DATA_W-1:0]              rf_wdata_o,
  output logic [NUM_SRC-1:0]             grant_o,
  output logic [NUM_SRC-1:0]             src_pending_o,
  output logic                           idle_o,
  output logic [15:0]                    contention_cnt_o,
  input  logic                           cnt_clr_i
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0]              push;
  logic [NUM_SRC-1:0]              full;
  logic [NUM_SRC-1:0]              empty;
  logic [NUM_SRC-1:0][ENTRY_W-1:0] head;
  logic [NUM_SRC-1:0][CNT_W-1:0]   fifo_cnt;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        contention_cnt_q, contention_cnt_d;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               gnt_found;
  logic               multi_pending;
  logic [ENTRY_W-1:0] head_sel;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Ready looks only at registered occupancy; x0 writes are acknowledged but dropped.
    assign src_ready_o[i] = (fifo_cnt[i] != CNT_W'(DEPTH));
    assign push[i]        = src_valid_i[i] & src_ready_o[i] & (src_waddr_i[i] != '0);

    cv32e40p_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (grant_o[i]),
      .wdata_i ({src_waddr_i[i], src_wdata_i[i]}),
      .rdata_o (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (fifo_cnt[i])
    );
  end

  assign src_pending_o = ~empty;
  assign idle_o        = ~|src_pending_o;
  assign rf_we_o       = |src_pending_o;
  assign multi_pending = |(src_pending_o & (src_pending_o - NUM_SRC'(1)));

  // Pick the winning head: lowest index, or first at/after rr_ptr in round-robin.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (PRIO_MODE == WB_PRIO_RR) cand_idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_SRC);
      else                         cand_idx = IDX_W'(k);
      if (!gnt_found && src_pending_o[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Drive the single write port from the granted head; zero when idle.
  always_comb begin
    grant_o  = '0;
    head_sel = '0;
    if (gnt_found) begin
      grant_o[gnt_idx] = 1'b1;
      head_sel         = head[gnt_idx];
    end
    rf_waddr_o = head_sel[ENTRY_W-1:DATA_W];
    rf_wdata_o = head_sel[DATA_W-1:0];
  end

  // Round-robin pointer advance and saturating contention count; clear wins.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
    contention_cnt_d = contention_cnt_q;
    if (cnt_clr_i) begin
      contention_cnt_d = '0;
    end else if (multi_pending && (contention_cnt_q != 16'hFFFF)) begin
      contention_cnt_d = contention_cnt_q + 16'd1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q         <= '0;
      contention_cnt_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign contention_cnt_o = contention_cnt_q;

  // Upstream must honour ready; a push into a full FIFO would lose data.
  assert property (@(posedge clk) disable iff (!rst_n) !(|(push & full)));

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Scoreboard bench: one FIXED and one RR arbiter instance, checked every cycle.
module tb_cv32e40p_wb_arbiter;
  import cv32e40p_pkg::*;

  localparam int NS = 3;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int EW = AW + DW;

  logic clk;
  logic rst_n;

  logic [NS-1:0]         valid  [2];
  logic [NS-1:0]         ready  [2];
  logic [NS-1:0][AW-1:0] waddr  [2];
  logic [NS-1:0][DW-1:0] wdata  [2];
  logic                  we     [2];
  logic [AW-1:0]         rwaddr [2];
  logic [DW-1:0]         rwdata [2];
  logic [NS-1:0]         grant  [2];
  logic [NS-1:0]         pend   [2];
  logic                  idle   [2];
  logic [15:0]           ccnt   [2];
  logic                  clr    [2];
  logic                  clr_req[2];

  logic [EW-1:0] stim_q [2*NS][$];
  logic [EW-1:0] exp_q  [2*NS][$];

  logic [15:0] cnt_m     [2];
  logic        prev_cont [2];
  int          rr_m;
  int          wait_m    [NS];

  int n_chk;
  int n_err;

  cv32e40p_wb_arbiter #(
    .NUM_SRC(NS), .DEPTH(2), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(WB_PRIO_FIXED)
  ) dut_f (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(valid[0]), .src_ready_o(ready[0]),
    .src_waddr_i(waddr[0]), .src_wdata_i(wdata[0]),
    .rf_we_o(we[0]), .rf_waddr_o(rwaddr[0]), .rf_wdata_o(rwdata[0]),
    .grant_o(grant[0]), .src_pending_o(pend[0]), .idle_o(idle[0]),
    .contention_cnt_o(ccnt[0]), .cnt_clr_i(clr[0])
  );

  cv32e40p_wb_arbiter #(
    .NUM_SRC(NS), .DEPTH(2), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(WB_PRIO_RR)
  ) dut_r (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(valid[1]), .src_ready_o(ready[1]),
    .src_waddr_i(waddr[1]), .src_wdata_i(wdata[1]),
    .rf_we_o(we[1]), .rf_waddr_o(rwaddr[1]), .rf_wdata_o(rwdata[1]),
    .grant_o(grant[1]), .src_pending_o(pend[1]), .idle_o(idle[1]),
    .contention_cnt_o(ccnt[1]), .cnt_clr_i(clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int j = 0; j < 2*NS; j++)
      if (stim_q[j].size() != 0 || exp_q[j].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle of stimulus at the falling edge; accepted pushes go to the scoreboard.
  task automatic step();
    logic [EW-1:0] e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < NS; s++) begin
        if (stim_q[d*NS+s].size() != 0) begin
          e = stim_q[d*NS+s][0];
          valid[d][s] = 1'b1;
          waddr[d][s] = e[EW-1:DW];
          wdata[d][s] = e[DW-1:0];
          if (ready[d][s]) begin
            void'(stim_q[d*NS+s].pop_front());
            if (e[EW-1:DW] != '0) exp_q[d*NS+s].push_back(e);
          end
        end else begin
          valid[d][s] = 1'b0;
          waddr[d][s] = '0;
          wdata[d][s] = '0;
        end
      end
      clr[d] = clr_req[d];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 2*NS; j++) begin
      stim_q[j].delete();
      exp_q[j].delete();
    end
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; waddr[d] = '0; wdata[d] = '0;
      clr[d] = 1'b0; clr_req[d] = 1'b0;
      cnt_m[d] = '0; prev_cont[d] = 1'b0;
    end
    rr_m = 0;
    for (int s = 0; s < NS; s++) wait_m[s] = 0;
    @(negedge clk);
    check_val("rst_we", we[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      step();
      n++;
    end
    step();
    check_val("drain_done", all_empty(), 1'b1);
    check_val("drain_idle", {idle[0], idle[1]}, 2'b11);
  endtask

  // Per-cycle scoreboard/model comparison for one DUT.
  task automatic monitor_dut(input int d);
    logic [NS-1:0] pm;
    logic [NS-1:0] eg;
    logic [EW-1:0] e;
    int gi;
    int s;
    if (!rst_n) begin
      check_val("rst_state", {ready[d], pend[d], grant[d], we[d], idle[d], ccnt[d]},
                {3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000});
      check_val("rst_port", {rwaddr[d], rwdata[d]}, '0);
      return;
    end
    pm = '0;
    for (int k = 0; k < NS; k++) pm[k] = (exp_q[d*NS+k].size() != 0);
    if (clr[d]) cnt_m[d] = '0;
    else if (prev_cont[d] && cnt_m[d] != 16'hFFFF) cnt_m[d] = cnt_m[d] + 16'd1;
    check_val($sformatf("cnt%0d", d), ccnt[d], cnt_m[d]);
    check_val($sformatf("pend%0d", d), pend[d], pm);
    check_val($sformatf("we_idle%0d", d), {we[d], idle[d]}, {|pm, pm == '0});
    eg = '0;
    gi = -1;
    for (int k = 0; k < NS; k++) begin
      s = (d == 0) ? k : (rr_m + k) % NS;
      if (gi < 0 && pm[s]) gi = s;
    end
    if (gi >= 0) eg[gi] = 1'b1;
    check_val($sformatf("grant%0d", d), grant[d], eg);
    if (gi >= 0) begin
      e = exp_q[d*NS+gi].pop_front();
      check_val($sformatf("wr%0d_src%0d", d, gi), {rwaddr[d], rwdata[d]}, e);
      if (d == 1) rr_m = (gi + 1) % NS;
    end else begin
      check_val($sformatf("wr%0d_zero", d), {rwaddr[d], rwdata[d]}, '0);
    end
    prev_cont[d] = ((pm & (pm - 3'd1)) != '0);
    if (d == 1) begin
      for (int k = 0; k < NS; k++) begin
        if (pend[1][k] && !grant[1][k]) wait_m[k]++;
        else wait_m[k] = 0;
        check_val("rr_wait", wait_m[k] > NS - 1, 1'b0);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) monitor_dut(d);
  end

  logic [NS-1:0] rr_seq [3];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    rr_m  = 0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; waddr[d] = '0; wdata[d] = '0;
      clr[d] = 1'b0; clr_req[d] = 1'b0;
      cnt_m[d] = '0; prev_cont[d] = 1'b0;
    end
    for (int s = 0; s < NS; s++) wait_m[s] = 0;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;

    repeat (2) @(negedge clk);
    check_val("por_state", {ready[0], idle[0], we[0], grant[0], ccnt[0]},
              {3'b111, 1'b1, 1'b0, 3'b000, 16'h0000});
    rst_n = 1'b1;

    // Single source write-through.
    stim_q[0].push_back({6'd5, 32'hDEAD_BEEF});
    step();
    step();
    check_val("t1_port", {we[0], rwaddr[0], rwdata[0]}, {1'b1, 6'd5, 32'hDEAD_BEEF});
    check_val("t1_grant", grant[0], 3'b001);
    step();
    check_val("t1_idle", idle[0], 1'b1);

    // Two sources collide under fixed priority.
    do_reset();
    stim_q[0].push_back({6'd3, 32'hAAAA_0003});
    stim_q[1].push_back({6'd4, 32'hBBBB_0004});
    step();
    step();
    check_val("t2_first", {grant[0], rwaddr[0]}, {3'b001, 6'd3});
    step();
    check_val("t2_second", {grant[0], rwaddr[0], rwdata[0]}, {3'b010, 6'd4, 32'hBBBB_0004});
    check_val("t2_cnt", ccnt[0], 16'd1);
    step();
    check_val("t2_cnt_hold", {idle[0], ccnt[0]}, {1'b1, 16'd1});

    // Round-robin with all sources saturating.
    do_reset();
    for (int k = 0; k < 6; k++)
      for (int s = 0; s < NS; s++)
        stim_q[NS+s].push_back({6'(1 + s*6 + k), 32'(32'hC000_0000 + s*256 + k)});
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check_val($sformatf("t3_rr_%0d", k), grant[1], rr_seq[k % 3]);
    end
    drain(60);

    // Backpressure on src2 while src0 holds fixed priority.
    do_reset();
    for (int k = 0; k < 8; k++) stim_q[0].push_back({6'(1 + k), 32'(32'h0A00_0000 + k)});
    for (int k = 0; k < 3; k++) stim_q[2].push_back({6'(17 + k), 32'(32'h2C00_0000 + k)});
    step();
    step();
    check_val("t4_ready_open", ready[0][2], 1'b1);
    step();
    check_val("t4_ready_full", ready[0][2], 1'b0);
    check_val("t4_held", stim_q[2].size(), 1);
    check_val("t4_mono", grant[0], 3'b001);
    drain(60);

    // x0 dropped, f0 stored.
    do_reset();
    stim_q[1].push_back({6'h00, 32'h1111_1111});
    stim_q[1].push_back({6'h20, 32'h2222_2222});
    step();
    step();
    check_val("t5_x0_dropped", {we[0], pend[0]}, {1'b0, 3'b000});
    step();
    check_val("t5_f0", {we[0], grant[0], rwaddr[0], rwdata[0]}, {1'b1, 3'b010, 6'h20, 32'h2222_2222});
    step();
    check_val("t5_idle", idle[0], 1'b1);

    // Reset with writes pending.
    do_reset();
    stim_q[0].push_back({6'd7, 32'h7777_0007});
    stim_q[1].push_back({6'd9, 32'h9999_0009});
    step();
    step();
    check_val("t6_pending", pend[0], 3'b011);
    do_reset();
    step();
    check_val("t6_after_rst", {ready[0], idle[0], we[0]}, {3'b111, 1'b1, 1'b0});

    // Counter saturation and clear.
    do_reset();
    for (int k = 0; k < 12; k++) stim_q[0].push_back({6'(1 + k), 32'(32'h5A00_0000 + k)});
    for (int k = 0; k < 4; k++) stim_q[1].push_back({6'(40 + k), 32'(32'h6B00_0000 + k)});
    repeat (4) step();
    force dut_f.contention_cnt_q = 16'hFFFF;
    cnt_m[0] = 16'hFFFF;
    #1;
    release dut_f.contention_cnt_q;
    step();
    check_val("t6_sat_a", ccnt[0], 16'hFFFF);
    step();
    check_val("t6_sat_b", ccnt[0], 16'hFFFF);
    clr_req[0] = 1'b1;
    step();
    clr_req[0] = 1'b0;
    step();
    check_val("t6_clr", ccnt[0], 16'h0000);
    drain(80);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
